data_mem_param: RTL and testbench
=================================

# data_mem_param

Parametrised single-port data memory: next generation of the processor's 8x256 data RAM. Adds configurable width, depth and read latency, a hardware initialisation sweep that fills every word with a constant after reset, and a software-triggered re-clear. Sits between the datapath's load/store unit and the memory array. `Busy` stalls the core until initialisation is complete.

## Interface

Parameters:
- `DW`, default 8: data width in bits.
- `AW`, default 8: address width in bits.
- `DEPTH`, default 256: number of words. Legal range 2 .. 2**AW.
- `READ_LAT`, default 0: read latency. 0 is a combinational read; 1 is a registered read.
- `FILL`, default 0: DW-bit value written to every word by the init sweep.

Ports:
- `Clk` (in, 1): clock. All state changes on the rising edge.
- `Reset` (in, 1): asynchronous, active-high reset.
- `WriteEn` (in, 1): write request.
- `ReadEn` (in, 1): read request.
- `Clear` (in, 1): synchronous request to re-run the init sweep.
- `DataAddress` (in, AW): single address for both read and write.
- `DataIn` (in, DW): write data.
- `DataOut` (out, DW): read data.
- `DataValid` (out, 1): `DataOut` carries the result of an accepted read.
- `Busy` (out, 1): init sweep in progress. Requests are ignored while this is high.

## Operation

- States: SWEEP and IDLE. Reset forces SWEEP with the sweep counter at 0.
- Reset does not clear the array itself. Contents become defined only through the sweep.
- SWEEP:
  - Each rising edge writes `FILL` to `core[cnt]`, then increments `cnt`.
  - On the edge that writes word DEPTH-1, the state changes to IDLE and `cnt` returns to 0.
  - `WriteEn`, `ReadEn` and `Clear` are ignored. `DataValid` is 0.
- IDLE:
  - Write: `WriteEn=1` with `DataAddress < DEPTH` writes `DataIn` at the edge.
  - Read: a read is accepted when `ReadEn=1`.
  - Clear: `Clear=1` at an edge moves the state to SWEEP with `cnt=0`. A `WriteEn` in the same cycle is dropped, and Clear wins.
- Out of range (`DataAddress >= DEPTH`): the write is dropped, and the read returns 0 with `DataValid` asserted normally.
- `WriteEn` and `ReadEn` may both be high in the same cycle.
- READ_LAT=0:
  - `DataOut = core[DataAddress]` combinationally.
  - `DataValid = ReadEn & ~Busy`, also combinational.
  - A simultaneous same-address write shows the old value until the edge and the new value after it.
- READ_LAT=1:
  - On an accepted read, `DataOut` registers the addressed word and `DataValid` pulses for exactly one cycle.
  - `DataOut` holds its last value when no read is accepted.
  - A simultaneous same-address write is write-first: `DataOut` returns `DataIn`.
- `Busy` is a registered output (state == SWEEP). It never glitches combinationally.

## Timing

- Output values during reset:
  - `Busy=1`.
  - `DataValid=0`.
  - `DataOut=0` when READ_LAT=1. When READ_LAT=0, `DataOut` is combinational and undefined until the sweep completes.
- Sweep duration:
  - The first rising edge after `Reset` deasserts writes word 0.
  - Edge k writes word k-1.
  - `Busy` falls after edge DEPTH.
  - The first request that can be accepted is sampled at edge DEPTH+1.
- Clear latency: with `Clear` sampled at edge n, `Busy` is high after edge n, and the sweep writes word 0 at edge n+1. `Busy` falls after edge n+DEPTH.
- `Clear` asserted while already in SWEEP has no effect. It does not restart the counter.
- Reset asserted mid-sweep or mid-read:
  - `Busy` goes to 1 immediately and `DataValid` goes to 0 immediately (asynchronous).
  - `cnt` goes to 0.
  - The sweep restarts from word 0 after release.
- Write latency: data written at edge n is visible combinationally after edge n (READ_LAT=0), or in `DataOut` after edge n+1 for a read issued in cycle n+1 (READ_LAT=1).
- Read latency: 0 cycles (READ_LAT=0) or 1 cycle (READ_LAT=1). Back-to-back reads are supported every cycle.

## Test plan

- **Reset sweep** (DEPTH=256, FILL=8'hA5, READ_LAT=1):
  - Release reset; count cycles → `Busy` is high for exactly 256 edges.
  - Then read 0, 200 and 255 → each returns 8'hA5 with a 1-cycle `DataValid` pulse.
- **Write/read**:
  - Write 8'h60 to address 200 and 8'h48 to address 201, then read 200, 201 back-to-back → `DataOut` is 8'h60, then 8'h48, with `DataValid` high for 2 consecutive cycles.
  - Repeat with READ_LAT=0 → values appear in the same cycle.
- **Write-first collision** (READ_LAT=1): write 8'h7E and read at address 207 in the same cycle → `DataOut` is 8'h7E the next cycle.
- **Ignored during Busy**:
  - Assert `WriteEn` with 8'hFF to address 5, and `ReadEn`, during the sweep → `DataValid` stays 0.
  - After the sweep, address 5 reads back as `FILL`.
- **Clear and reset mid-operation**:
  - Write 8'h72 to address 3, then pulse `Clear` together with `WriteEn` to address 4 → `Busy` is high for 256 cycles, and addresses 3 and 4 both read `FILL`.
  - Assert `Reset` at sweep count 100 → `Busy` stays high, and the full 256-cycle sweep reruns after release.
- **Out of range** (DEPTH=200, AW=8): write 8'h5C to address 210, then read address 210 → `DataOut`=0 with `DataValid`=1. Address 199 is writable and readable.

Source files
------------

// File: rtl/data_mem_param.sv
// Single-port data memory with configurable width, depth and read latency.
// After reset (or a Clear request) a sweep fills every word with FILL while Busy is high.
module data_mem_param #(
  parameter int              DW       = 8,
  parameter int              AW       = 8,
  parameter int              DEPTH    = 256,
  parameter int              READ_LAT = 0,
  parameter logic [DW-1:0]   FILL     = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WriteEn,
  input  logic          ReadEn,
  input  logic          Clear,
  input  logic [AW-1:0] DataAddress,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] DataOut,
  output logic          DataValid,
  output logic          Busy,
  output logic [0:0]    fsm_state
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SWEEP = 1'b1;
  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic [DW-1:0] core [DEPTH];

  logic idle;
  logic in_range;
  logic wr_go;
  logic rd_go;
  logic sweep_we;

  // Read handshake: a read is accepted in any cycle where ReadEn=1 and Busy=0;
  // DataValid marks the cycle in which DataOut carries that read's data
  // (same cycle for READ_LAT=0, next cycle for READ_LAT=1). There is no
  // back-pressure: DataValid is a one-cycle pulse per accepted read.
  assign idle      = (state == ST_IDLE);
  assign in_range  = ({1'b0, DataAddress} < DEPTH_W);
  assign wr_go     = idle & WriteEn & ~Clear & in_range;
  assign rd_go     = idle & ReadEn;
  assign sweep_we  = (state == ST_SWEEP) & ~Reset;
  assign Busy      = (state == ST_SWEEP);
  assign fsm_state = state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_SWEEP;
      cnt   <= '0;
    end else if (state == ST_SWEEP) begin
      if (cnt == LAST) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + AW'(1);
      end
    end else if (Clear) begin
      state <= ST_SWEEP;
      cnt   <= '0;
    end
  end

  // The array has no reset; its contents become defined only through the sweep.
  always_ff @(posedge Clk) begin
    if (sweep_we) begin
      core[cnt] <= FILL;
    end else if (wr_go) begin
      core[DataAddress] <= DataIn;
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb_read
      always_comb begin
        DataOut = '0;
        if (in_range) begin
          DataOut = core[DataAddress];
        end
      end
      assign DataValid = rd_go;
    end else begin : g_reg_read
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          DataOut   <= '0;
          DataValid <= 1'b0;
        end else begin
          DataValid <= rd_go;
          if (rd_go) begin
            if (!in_range) begin
              DataOut <= '0;
            end else if (wr_go) begin
              // Same-cycle write to the read address is write-first.
              DataOut <= DataIn;
            end else begin
              DataOut <= core[DataAddress];
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_param.sv
// Directed bench for data_mem_param: three instances (registered read, combinational
// read, and a 200-word registered-read memory) share one set of inputs.
module tb_data_mem_param;

  logic       clk;
  logic       rst;
  logic       we;
  logic       re;
  logic       clr;
  logic [7:0] addr;
  logic [7:0] din;

  logic [7:0] dout1, dout0, dout_r;
  logic       dv1, dv0, dv_r;
  logic       busy1, busy0, busy_r;
  logic [0:0] st1, st0, st_r;

  int tests_run;
  int fails;

  data_mem_param #(.DW(8), .AW(8), .DEPTH(256), .READ_LAT(1), .FILL(8'hA5)) u_l1 (
    .Clk(clk), .Reset(rst), .WriteEn(we), .ReadEn(re), .Clear(clr),
    .DataAddress(addr), .DataIn(din), .DataOut(dout1), .DataValid(dv1),
    .Busy(busy1), .fsm_state(st1)
  );

  data_mem_param #(.DW(8), .AW(8), .DEPTH(256), .READ_LAT(0), .FILL(8'hA5)) u_l0 (
    .Clk(clk), .Reset(rst), .WriteEn(we), .ReadEn(re), .Clear(clr),
    .DataAddress(addr), .DataIn(din), .DataOut(dout0), .DataValid(dv0),
    .Busy(busy0), .fsm_state(st0)
  );

  data_mem_param #(.DW(8), .AW(8), .DEPTH(200), .READ_LAT(1), .FILL(8'h00)) u_r (
    .Clk(clk), .Reset(rst), .WriteEn(we), .ReadEn(re), .Clear(clr),
    .DataAddress(addr), .DataIn(din), .DataOut(dout_r), .DataValid(dv_r),
    .Busy(busy_r), .fsm_state(st_r)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; din = d;
    tick();
    we = 1'b0;
  endtask

  // Registered read on u_l1 and combinational read on u_l0 of the same address.
  task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input string name);
    re = 1'b1; addr = a;
    #1;
    tests_run++;
    if (dout0 !== exp || dv0 !== 1'b1) begin
      fails++;
      $display("FAIL %s lat0: dout=%h dv=%b, want dout=%h dv=1", name, dout0, dv0, exp);
    end
    tick();
    tests_run++;
    if (dout1 !== exp || dv1 !== 1'b1) begin
      fails++;
      $display("FAIL %s lat1: dout=%h dv=%b, want dout=%h dv=1", name, dout1, dv1, exp);
    end
    re = 1'b0;
    tick();
    tests_run++;
    if (dv1 !== 1'b0 || dout1 !== exp) begin
      fails++;
      $display("FAIL %s lat1 pulse: dv=%b dout=%h, want dv=0 dout=%h held", name, dv1, dout1, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b0; addr = '0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy1 !== 1'b1 || busy0 !== 1'b1 || busy_r !== 1'b1) begin
      fails++;
      $display("FAIL reset_busy: busy=%b%b%b, want 111", busy1, busy0, busy_r);
    end
    tests_run++;
    if (dv1 !== 1'b0 || dv0 !== 1'b0 || dv_r !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: dv=%b%b%b, want 000", dv1, dv0, dv_r);
    end
    tests_run++;
    if (dout1 !== 8'h00 || dout_r !== 8'h00) begin
      fails++;
      $display("FAIL reset_dout: dout1=%h dout_r=%h, want 00 00", dout1, dout_r);
    end
    tests_run++;
    if (st1 !== 1'b1 || st0 !== 1'b1 || st_r !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: st=%b%b%b, want 111", st1, st0, st_r);
    end
  endtask

  // Release reset and count sweep edges; requests during the sweep must be ignored.
  task automatic test_sweep();
    int n;
    int bad_dv;
    n = 0; bad_dv = 0;
    rst = 1'b0;
    while (busy1 && n < 400) begin
      if (n == 10) begin we = 1'b1; re = 1'b1; addr = 8'd5; din = 8'hFF; end
      if (n == 60) begin we = 1'b0; re = 1'b0; end
      tick();
      n++;
      if (dv1 || dv0) bad_dv++;
    end
    tests_run++;
    if (n !== 256) begin
      fails++;
      $display("FAIL sweep_len: busy edges=%0d, want 256", n);
    end
    tests_run++;
    if (bad_dv !== 0) begin
      fails++;
      $display("FAIL busy_ignore_valid: dv cycles=%0d, want 0", bad_dv);
    end
    tests_run++;
    if (busy0 !== 1'b0 || busy_r !== 1'b0 || st1 !== 1'b0) begin
      fails++;
      $display("FAIL sweep_done: busy0=%b busy_r=%b st1=%b, want 0 0 0", busy0, busy_r, st1);
    end
    do_read(8'd0,   8'hA5, "fill_0");
    do_read(8'd200, 8'hA5, "fill_200");
    do_read(8'd255, 8'hA5, "fill_255");
    do_read(8'd5,   8'hA5, "busy_write_dropped");
  endtask

  task automatic test_write_read();
    do_write(8'd200, 8'h60);
    do_write(8'd201, 8'h48);
    re = 1'b1; addr = 8'd200;
    #1;
    tests_run++;
    if (dout0 !== 8'h60 || dv0 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_lat0_a: dout=%h dv=%b, want 60 1", dout0, dv0);
    end
    tick();
    tests_run++;
    if (dout1 !== 8'h60 || dv1 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_lat1_a: dout=%h dv=%b, want 60 1", dout1, dv1);
    end
    tests_run++;
    if (dout_r !== 8'h00 || dv_r !== 1'b1) begin
      fails++;
      $display("FAIL oor_200: dout=%h dv=%b, want 00 1", dout_r, dv_r);
    end
    addr = 8'd201;
    #1;
    tests_run++;
    if (dout0 !== 8'h48 || dv0 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_lat0_b: dout=%h dv=%b, want 48 1", dout0, dv0);
    end
    tick();
    tests_run++;
    if (dout1 !== 8'h48 || dv1 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_lat1_b: dout=%h dv=%b, want 48 1", dout1, dv1);
    end
    re = 1'b0;
    tick();
    tests_run++;
    if (dv1 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end: dv=%b, want 0", dv1);
    end
  endtask

  task automatic test_collision();
    we = 1'b1; re = 1'b1; addr = 8'd207; din = 8'h7E;
    #1;
    tests_run++;
    if (dout0 !== 8'hA5) begin
      fails++;
      $display("FAIL coll_lat0_before: dout=%h, want a5", dout0);
    end
    tick();
    we = 1'b0; re = 1'b0;
    #1;
    tests_run++;
    if (dout1 !== 8'h7E || dv1 !== 1'b1) begin
      fails++;
      $display("FAIL coll_lat1_write_first: dout=%h dv=%b, want 7e 1", dout1, dv1);
    end
    tests_run++;
    if (dout0 !== 8'h7E) begin
      fails++;
      $display("FAIL coll_lat0_after: dout=%h, want 7e", dout0);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    do_write(8'd199, 8'h3C);
    do_write(8'd210, 8'h5C);
    re = 1'b1; addr = 8'd199;
    tick();
    tests_run++;
    if (dout_r !== 8'h3C || dv_r !== 1'b1) begin
      fails++;
      $display("FAIL oor_199: dout=%h dv=%b, want 3c 1", dout_r, dv_r);
    end
    addr = 8'd210;
    tick();
    tests_run++;
    if (dout_r !== 8'h00 || dv_r !== 1'b1) begin
      fails++;
      $display("FAIL oor_210: dout=%h dv=%b, want 00 1", dout_r, dv_r);
    end
    tests_run++;
    if (dout1 !== 8'h5C) begin
      fails++;
      $display("FAIL inrange_210_big: dout=%h, want 5c", dout1);
    end
    re = 1'b0;
    tick();
  endtask

  // Clear wins over a same-cycle write; a second Clear mid-sweep must not restart it.
  task automatic test_clear();
    int n;
    do_write(8'd3, 8'h72);
    clr = 1'b1; we = 1'b1; addr = 8'd4; din = 8'h11;
    tick();
    clr = 1'b0; we = 1'b0;
    tests_run++;
    if (busy1 !== 1'b1 || busy0 !== 1'b1) begin
      fails++;
      $display("FAIL clear_busy: busy1=%b busy0=%b, want 1 1", busy1, busy0);
    end
    n = 0;
    while (busy1 && n < 400) begin
      clr = (n == 50);
      tick();
      n++;
    end
    clr = 1'b0;
    tests_run++;
    if (n !== 256) begin
      fails++;
      $display("FAIL clear_len: busy edges=%0d, want 256", n);
    end
    do_read(8'd3, 8'hA5, "clear_addr3");
    do_read(8'd4, 8'hA5, "clear_addr4");
  endtask

  task automatic test_reset_mid();
    int n;
    re = 1'b1; addr = 8'd0;
    tick();
    tests_run++;
    if (dv1 !== 1'b1) begin
      fails++;
      $display("FAIL mid_read_pre: dv=%b, want 1", dv1);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (dv1 !== 1'b0 || dv0 !== 1'b0 || busy1 !== 1'b1 || dout1 !== 8'h00) begin
      fails++;
      $display("FAIL async_reset: dv1=%b dv0=%b busy=%b dout=%h, want 0 0 1 00", dv1, dv0, busy1, dout1);
    end
    tick();
    rst = 1'b0; re = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    #2 rst = 1'b1;
    tick();
    tests_run++;
    if (busy1 !== 1'b1 || st1 !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_sweep: busy=%b st=%b, want 1 1", busy1, st1);
    end
    rst = 1'b0;
    n = 0;
    while (busy1 && n < 400) begin
      tick();
      n++;
    end
    tests_run++;
    if (n !== 256) begin
      fails++;
      $display("FAIL reset_rerun_len: busy edges=%0d, want 256", n);
    end
    do_read(8'd200, 8'hA5, "after_rerun_200");
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    test_reset();
    test_sweep();
    test_write_read();
    test_collision();
    test_out_of_range();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
